// File: rtl/otter_regfile.sv
// OTTER RV32I integer register file: 32 x 32 bits, two combinational read
// ports, one synchronous write port, x0 hardwired to zero.
module otter_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  r_addr1,
  input  logic [4:0]  r_addr2,
  input  logic        w_en,
  input  logic [4:0]  w_addr,
  input  logic [31:0] w_data,
  output logic [31:0] r_rs1,
  output logic [31:0] r_rs2
);

  logic [31:0] mem [32];

  // Reset wins over a same-cycle write; writes to x0 are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 32; i++) begin
        mem[i] <= '0;
      end
    end else if (w_en && (w_addr != 5'd0)) begin
      mem[w_addr] <= w_data;
    end
  end

  // x0 is forced at the read mux so it reads zero regardless of array contents.
  always_comb begin
    r_rs1 = '0;
    r_rs2 = '0;
    if (r_addr1 != 5'd0) r_rs1 = mem[r_addr1];
    if (r_addr2 != 5'd0) r_rs2 = mem[r_addr2];
  end

endmodule

// File: tb/tb_otter_regfile.sv
// Directed, table-driven bench for otter_regfile with hand-written sequences
// for reset priority, same-edge read/write and the full register sweep.
module tb_otter_regfile;

  logic        clk;
  logic        rst_n;
  logic [4:0]  r_addr1;
  logic [4:0]  r_addr2;
  logic        w_en;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic [31:0] r_rs1;
  logic [31:0] r_rs2;

  int unsigned n_cmp;
  int unsigned n_fail;

  otter_regfile dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .r_addr1 (r_addr1),
    .r_addr2 (r_addr2),
    .w_en    (w_en),
    .w_addr  (w_addr),
    .w_data  (w_data),
    .r_rs1   (r_rs1),
    .r_rs2   (r_rs2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t        vecs [17];
  logic [31:0] pats [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    w_en    = 1'b0;
    w_addr  = '0;
    w_data  = '0;
    r_addr1 = '0;
    r_addr2 = '0;

    pats[0] = 32'h00000000; pats[1] = 32'hFFFFFFFF;
    pats[2] = 32'hAAAAAAAA; pats[3] = 32'h55555555;
    pats[4] = 32'h12345678; pats[5] = 32'h87654321;
    pats[6] = 32'hF0F0F0F0; pats[7] = 32'h0F0F0F0F;

    // Each vector: drive write + read addresses, clock once, check reads.
    vecs[0]  = '{1'b1, 5'd1,  32'hDEADBEEF, 5'd1,  5'd0,  32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b1, 5'd0,  32'hDEADBEEF, 5'd0,  5'd1,  32'h0,        32'hDEADBEEF};
    vecs[2]  = '{1'b1, 5'd5,  32'h12345678, 5'd5,  5'd1,  32'h12345678, 32'hDEADBEEF};
    vecs[3]  = '{1'b1, 5'd10, 32'h87654321, 5'd5,  5'd10, 32'h12345678, 32'h87654321};
    vecs[4]  = '{1'b1, 5'd3,  32'hABCDEF00, 5'd3,  5'd3,  32'hABCDEF00, 32'hABCDEF00};
    vecs[5]  = '{1'b0, 5'd3,  32'h11111111, 5'd3,  5'd10, 32'hABCDEF00, 32'h87654321};
    vecs[6]  = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd0,  32'hFFFFFFFF, 32'h0};
    for (int unsigned k = 0; k < 8; k++) begin
      vecs[7 + k] = '{1'b1, 5'(20 + k), pats[k], 5'(20 + k), 5'd31, pats[k], 32'hFFFFFFFF};
    end
    vecs[15] = '{1'b0, 5'd20, 32'hDEADBEEF, 5'd20, 5'd21, 32'h00000000, 32'hFFFFFFFF};
    vecs[16] = '{1'b0, 5'd0,  32'h0,        5'd22, 5'd27, 32'hAAAAAAAA, 32'h0F0F0F0F};

    // Initial reset, then x5 write followed by a reset cycle that also carries a write.
    step();
    rst_n = 1'b1;
    w_en = 1'b1; w_addr = 5'd5; w_data = 32'h12345678; r_addr1 = 5'd5;
    step();
    check("pre_reset_x5", r_rs1, 32'h12345678);
    rst_n = 1'b0;
    w_addr = 5'd6; w_data = 32'hA5A5A5A5; r_addr2 = 5'd6;
    step();
    rst_n = 1'b1;
    w_en = 1'b0;
    check("reset_clears_x5", r_rs1, 32'h0);
    check("reset_beats_write_x6", r_rs2, 32'h0);
    for (int unsigned i = 0; i < 32; i++) begin
      r_addr1 = 5'(i);
      r_addr2 = 5'(31 - i);
      #1;
      check($sformatf("reset_sweep_p1_x%0d", i), r_rs1, 32'h0);
      check($sformatf("reset_sweep_p2_x%0d", 31 - i), r_rs2, 32'h0);
    end

    for (int unsigned v = 0; v < 17; v++) begin
      w_en = vecs[v].we; w_addr = vecs[v].wa; w_data = vecs[v].wd;
      r_addr1 = vecs[v].ra1; r_addr2 = vecs[v].ra2;
      step();
      check($sformatf("vec%0d_rs1", v), r_rs1, vecs[v].e1);
      check($sformatf("vec%0d_rs2", v), r_rs2, vecs[v].e2);
    end

    // Read x15 while writing x16 (x16 still zero from reset).
    w_en = 1'b1; w_addr = 5'd15; w_data = 32'hCAFEBABE;
    step();
    r_addr1 = 5'd15; r_addr2 = 5'd16;
    w_addr = 5'd16; w_data = 32'hDEADC0DE;
    #1;
    check("rw_other_pre_rs1", r_rs1, 32'hCAFEBABE);
    check("rw_other_pre_rs2", r_rs2, 32'h0);
    step();
    check("rw_other_post_rs1", r_rs1, 32'hCAFEBABE);
    check("rw_other_post_rs2", r_rs2, 32'hDEADC0DE);

    // Read x7 across its own write edge: old value, then new.
    w_addr = 5'd7; w_data = 32'h07070707;
    step();
    r_addr1 = 5'd7;
    w_data = 32'h77777777;
    #1;
    check("rw_same_before_edge", r_rs1, 32'h07070707);
    step();
    check("rw_same_after_edge", r_rs1, 32'h77777777);

    // Back-to-back writes to one address: last one wins.
    w_addr = 5'd9; w_data = 32'h99990001; r_addr2 = 5'd9;
    step();
    w_data = 32'h99990002;
    step();
    w_en = 1'b0; w_data = 32'h0;
    step();
    check("last_write_wins_x9", r_rs2, 32'h99990002);

    // Full sweep over x1..x31.
    w_en = 1'b1;
    for (int unsigned i = 1; i < 32; i++) begin
      w_addr = 5'(i);
      w_data = 32'h1000_0000 + 32'(i);
      step();
    end
    w_en = 1'b0;
    w_addr = 5'd0;
    w_data = 32'hFFFFFFFF;
    for (int unsigned i = 0; i < 32; i++) begin
      r_addr1 = 5'(i);
      r_addr2 = 5'(31 - i);
      #1;
      check($sformatf("sweep_p1_x%0d", i), r_rs1,
            (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i));
      check($sformatf("sweep_p2_x%0d", 31 - i), r_rs2,
            (i == 31) ? 32'h0 : 32'h1000_0000 + 32'(31 - i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
